// File: rtl/cd_es_param_if.sv
// Datapath <-> control/program-memory bus for cd_es_param.
// The control side drives instruction and strobes; the datapath returns PC, opcode, ports and flags.
interface cd_es_param_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned PW   = 10,
  parameter int unsigned NIN  = 4,
  parameter int unsigned NOUT = 4
);
  logic [15:0]        instr;
  logic [PW-1:0]      pc;
  logic [5:0]         opcode;
  logic               s_inc;
  logic               s_inm;
  logic               s_in;
  logic               we3;
  logic               wez;
  logic [2:0]         op_alu;
  logic               call;
  logic               ret;
  logic               we_out;
  logic [NIN*DW-1:0]  in_data;
  logic [NOUT*DW-1:0] out_data;
  logic               s_z;
  logic               stack_full;
  logic               stack_empty;
  logic               stack_err;

  modport master (
    output instr, s_inc, s_inm, s_in, we3, wez, op_alu, call, ret, we_out, in_data,
    input  pc, opcode, out_data, s_z, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  instr, s_inc, s_inm, s_in, we3, wez, op_alu, call, ret, we_out, in_data,
    output pc, opcode, out_data, s_z, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/cd_es_param.sv
// Parametrised single-cycle datapath: PC with return stack, 16-entry register file,
// DW-wide ALU, zero flag, synchronised input ports and registered output ports.
module cd_es_param #(
  parameter int unsigned DW   = 8,
  parameter int unsigned PW   = 10,
  parameter int unsigned SD   = 4,
  parameter int unsigned NIN  = 4,
  parameter int unsigned NOUT = 4
) (
  input logic         clk,
  input logic         reset,
  cd_es_param_if.slave bus
);

  localparam int unsigned SPW = $clog2(SD + 1);

  logic [PW-1:0]      pc_q;
  logic [PW-1:0]      pc_inc;
  logic [PW-1:0]      pc_jmp;
  logic [PW-1:0]      pc_next;
  logic [PW-1:0]      stk_top;
  logic [PW-1:0]      stk [SD];
  logic [SPW-1:0]     sp;
  logic               stk_empty;
  logic               stk_full;
  logic               push;
  logic               pop;
  logic               err_set;
  logic               err_q;
  logic               z_q;

  logic [DW-1:0]      rf [16];
  logic [DW-1:0]      rd1;
  logic [DW-1:0]      rd2;
  logic [DW-1:0]      alu_y;
  logic               zalu;
  logic [DW-1:0]      wd3;
  logic [DW-1:0]      in_sel_data;
  logic [3:0]         in_sel;
  logic [3:0]         out_sel;

  logic [NIN*DW-1:0]  sync1;
  logic [NIN*DW-1:0]  sync2;
  logic [NOUT*DW-1:0] out_q;

  assign bus.pc          = pc_q;
  assign bus.opcode      = bus.instr[15:10];
  assign bus.out_data    = out_q;
  assign bus.s_z         = z_q;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.stack_err   = err_q;

  assign pc_inc    = pc_q + PW'(1);
  assign pc_jmp    = bus.instr[PW-1:0];
  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == SPW'(SD));
  assign in_sel    = 4'(32'(bus.instr[7:4]) % NIN);
  assign out_sel   = 4'(32'(bus.instr[3:0]) % NOUT);

  // R0 is hardwired to zero on both read ports
  assign rd1 = (bus.instr[11:8] == 4'd0) ? '0 : rf[bus.instr[11:8]];
  assign rd2 = (bus.instr[7:4]  == 4'd0) ? '0 : rf[bus.instr[7:4]];

  // Return-stack top: entry below the pointer
  always_comb begin
    stk_top = '0;
    for (int unsigned k = 0; k < SD; k++) begin
      if (sp == SPW'(k + 1)) stk_top = stk[k];
    end
  end

  // Next PC and stack control; ret wins over call, which wins over s_inc
  always_comb begin
    pc_next = bus.s_inc ? pc_inc : pc_jmp;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (bus.ret) begin
      if (bus.call) err_set = 1'b1;
      if (!stk_empty) begin
        pc_next = stk_top;
        pop     = 1'b1;
      end else begin
        pc_next = pc_inc;
        err_set = 1'b1;
      end
    end else if (bus.call) begin
      pc_next = pc_jmp;
      if (!stk_full) push    = 1'b1;
      else           err_set = 1'b1;
    end
  end

  always_comb begin
    unique case (bus.op_alu)
      3'b000:  alu_y = rd1;
      3'b001:  alu_y = ~rd1;
      3'b010:  alu_y = rd1 + rd2;
      3'b011:  alu_y = rd1 - rd2;
      3'b100:  alu_y = rd1 & rd2;
      3'b101:  alu_y = rd1 | rd2;
      3'b110:  alu_y = DW'(0) - rd1;
      default: alu_y = DW'(0) - rd2;
    endcase
  end

  assign zalu = (alu_y == '0);

  // Write-back source: second synchroniser stage of the selected input port
  always_comb begin
    in_sel_data = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (in_sel == 4'(k)) in_sel_data = sync2[k*DW +: DW];
    end
  end

  always_comb begin
    if (bus.s_in)       wd3 = in_sel_data;
    else if (bus.s_inm) wd3 = DW'(bus.instr[11:4]);
    else                wd3 = alu_y;
  end

  // Register file and stack storage carry no reset; writes are blocked while reset is high
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (bus.we3) rf[bus.instr[3:0]] <= wd3;
      for (int unsigned k = 0; k < SD; k++) begin
        if (push && (sp == SPW'(k))) stk[k] <= pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      sp    <= '0;
      err_q <= 1'b0;
      z_q   <= 1'b0;
      sync1 <= '0;
      sync2 <= '0;
      out_q <= '0;
    end else begin
      pc_q  <= pc_next;
      if (push)     sp <= sp + SPW'(1);
      else if (pop) sp <= sp - SPW'(1);
      if (err_set) err_q <= 1'b1;
      if (bus.wez) z_q   <= zalu;
      sync1 <= bus.in_data;
      sync2 <= sync1;
      if (bus.we_out) begin
        for (int unsigned k = 0; k < NOUT; k++) begin
          if (out_sel == 4'(k)) out_q[k*DW +: DW] <= rd1;
        end
      end
    end
  end

endmodule
